// File: rtl/fix_bfp_norm.sv
// rtl/fix_bfp_norm.sv - block-floating-point frame normalizer
// Buffers a frame, finds the common redundant-sign-bit count, streams it back shifted.
module fix_bfp_norm #(
   parameter int WIDTH     = 16,
   parameter int FRAME_LEN = 8,
   parameter int EXP_WIDTH = $clog2(WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [EXP_WIDTH-1:0] out_exp,
   output logic                 out_last,
   output logic                 out_valid,
   input  logic                 out_ready
);

   localparam int PTR_WIDTH = $clog2(FRAME_LEN);
   localparam logic ST_FILL  = 1'b0;
   localparam logic ST_DRAIN = 1'b1;
   localparam logic [EXP_WIDTH-1:0] RSB_MAX  = EXP_WIDTH'(WIDTH - 1);
   localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(FRAME_LEN - 1);

   // Leading bits matching the sign bit, excluding the sign bit itself.
   function automatic logic [EXP_WIDTH-1:0] rsb(input logic [WIDTH-1:0] x);
      logic [EXP_WIDTH-1:0] n;
      logic                 run;
      n   = '0;
      run = 1'b1;
      for (int i = WIDTH - 2; i >= 0; i--) begin
         if (run && (x[i] == x[WIDTH-1])) n = n + EXP_WIDTH'(1);
         else                             run = 1'b0;
      end
      return n;
   endfunction

   logic                 state;
   logic [WIDTH-1:0]     mem [FRAME_LEN];
   logic [PTR_WIDTH-1:0] wr_ptr;
   logic [PTR_WIDTH-1:0] rd_ptr;
   logic [EXP_WIDTH-1:0] min_rsb;
   logic [EXP_WIDTH-1:0] shift_exp;
   logic [EXP_WIDTH-1:0] in_rsb;
   logic [EXP_WIDTH-1:0] frame_min;
   logic                 accept;
   logic                 xfer;

   assign in_rsb    = rsb(in_data);
   assign frame_min = (in_rsb < min_rsb) ? in_rsb : min_rsb;
   assign in_ready  = (state == ST_FILL);
   assign out_valid = (state == ST_DRAIN);
   assign accept    = in_valid && in_ready;
   assign xfer      = out_valid && out_ready;

   assign out_data  = out_valid ? (mem[rd_ptr] << shift_exp) : '0;
   assign out_exp   = out_valid ? shift_exp : '0;
   assign out_last  = out_valid && (rd_ptr == PTR_LAST);

   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_FILL;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         min_rsb   <= RSB_MAX;
         shift_exp <= '0;
      end else if (state == ST_FILL) begin
         if (accept) begin
            if (wr_ptr == PTR_LAST) begin
               shift_exp <= frame_min;
               min_rsb   <= RSB_MAX;
               wr_ptr    <= '0;
               state     <= ST_DRAIN;
            end else begin
               min_rsb <= frame_min;
               wr_ptr  <= wr_ptr + PTR_WIDTH'(1);
            end
         end
      end else if (xfer) begin
         if (rd_ptr == PTR_LAST) begin
            rd_ptr <= '0;
            state  <= ST_FILL;
         end else begin
            rd_ptr <= rd_ptr + PTR_WIDTH'(1);
         end
      end
   end

endmodule
